// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states; the encoding is visible on the seq_state debug port.
    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_CNT_W         = 8;

    // Largest of three values; used to size the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous status bit.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, qualifies lock
// stability and only then releases the downstream core reset. Runs from the
// free-running reference clock so it keeps working while the PLL is unlocked.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic             soft_rst,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             locked_ok,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count,
    output logic             timeout_err
);

    // PLL_RST counts one step further than the other phases (entry cycle plus
    // RST_CYCLES), so its terminal value is RST_CYCLES rather than RST_CYCLES-1.
    localparam int TMR_MAX = max3(RST_CYCLES + 1, STABLE_CYCLES, LOCK_TIMEOUT);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_lk;
    logic             w_timeout;
    logic             w_loss;
    logic             r_pll_rst;
    logic             r_sys_reset;
    logic             r_locked_ok;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_loss_count;
    logic [CNT_W-1:0] r_retry_count;

    sync_2ff u_lock_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (pll_locked),
        .o_q     (w_lk)
    );

    // Next-state and timer logic; soft_rst overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + TMR_W'(1);
        w_timeout   = 1'b0;
        w_loss      = 1'b0;
        if (soft_rst) begin
            w_state_nxt = S_PLL_RST;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                S_PLL_RST: begin
                    if (r_timer == RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lk) begin
                        w_state_nxt = S_STABLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == TMO_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_PLL_RST;
                        w_timer_nxt = '0;
                    end
                end
                S_STABLE: begin
                    if (!w_lk) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end else if (r_timer == STB_LAST) begin
                        w_state_nxt = S_RUN;
                        w_timer_nxt = '0;
                    end
                end
                S_RUN: begin
                    w_timer_nxt = '0;
                    if (!w_lk) begin
                        w_loss      = 1'b1;
                        w_state_nxt = S_WAIT_LOCK;
                    end
                end
                default: begin
                    w_state_nxt = S_PLL_RST;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // State register plus outputs registered from the next state, so they
    // change in the same cycle as seq_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_PLL_RST;
            r_timer       <= '0;
            r_pll_rst     <= 1'b1;
            r_sys_reset   <= 1'b1;
            r_locked_ok   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_pll_rst     <= (w_state_nxt == S_PLL_RST);
            r_sys_reset   <= (w_state_nxt != S_RUN);
            r_locked_ok   <= (w_state_nxt == S_RUN);
            r_timeout_err <= w_timeout;
        end
    end

    // Saturating diagnostic counters; only a block reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_loss_count  <= '0;
            r_retry_count <= '0;
        end else begin
            if (w_loss && (r_loss_count != CNT_MAX)) begin
                r_loss_count <= r_loss_count + CNT_W'(1);
            end
            if (w_timeout && (r_retry_count != CNT_MAX)) begin
                r_retry_count <= r_retry_count + CNT_W'(1);
            end
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_reset   = r_sys_reset;
    assign locked_ok   = r_locked_ok;
    assign seq_state   = r_state;
    assign loss_count  = r_loss_count;
    assign retry_count = r_retry_count;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with small parameters (4/8/32, 4-bit counters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pll_reset_sequencer;

    localparam int RST    = 4;
    localparam int STB    = 8;
    localparam int TMO    = 32;
    localparam int CNT_W  = 4;
    localparam int SAT    = 15;

    logic             clk;
    logic             reset;
    logic             pll_locked;
    logic             soft_rst;
    logic             pll_rst;
    logic             sys_reset;
    logic             locked_ok;
    logic [1:0]       seq_state;
    logic [CNT_W-1:0] loss_count;
    logic [CNT_W-1:0] retry_count;
    logic             timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    pll_reset_sequencer #(
        .RST_CYCLES    (RST),
        .STABLE_CYCLES (STB),
        .LOCK_TIMEOUT  (TMO),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .soft_rst    (soft_rst),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .locked_ok   (locked_ok),
        .seq_state   (seq_state),
        .loss_count  (loss_count),
        .retry_count (retry_count),
        .timeout_err (timeout_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_soft_rst();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
    endtask

    // Counts consecutive sampled cycles with pll_rst high, starting now.
    task automatic count_pll_rst(output int cnt);
        cnt = 0;
        while (pll_rst === 1'b1 && cnt < 50) begin
            cnt++;
            tick();
        end
    endtask

    function automatic bit cond_met(input int sel);
        case (sel)
            0:       return (sys_reset === 1'b0);
            1:       return (timeout_err === 1'b1);
            default: return (seq_state === 2'd2);
        endcase
    endfunction

    // Ticks until the selected condition holds or the budget runs out;
    // an expired budget returns max_cyc, which never matches an expectation.
    task automatic wait_cond(input int sel, input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cond_met(sel) && n < max_cyc);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"},   seq_state,   0);
        check_eq({tag, "_pll_rst"}, pll_rst,     1);
        check_eq({tag, "_sys_rst"}, sys_reset,   1);
        check_eq({tag, "_lk_ok"},   locked_ok,   0);
        check_eq({tag, "_loss"},    loss_count,  0);
        check_eq({tag, "_retry"},   retry_count, 0);
        check_eq({tag, "_tmo"},     timeout_err, 0);
    endtask

    initial begin
        int n;
        int cnt;
        int exp_loss;
        int exp_retry;

        reset      = 1'b1;
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        exp_loss   = 0;
        exp_retry  = 0;
        repeat (3) tick();
        check_reset_values("rst");

        // Power-up: PLL reset pulse, then lock 10 cycles after release.
        reset = 1'b0;
        tick();
        count_pll_rst(cnt);
        check_eq("pll_rst_len_boot", cnt, RST);
        check_eq("boot_wait_state", seq_state, 1);
        repeat (5) tick();
        pll_locked = 1'b1;
        exp_q.push_back(2 + 1 + STB);
        wait_cond(0, 100, n);
        check_eq("lock_to_run", n, exp_q.pop_front());
        check_eq("run_state", seq_state, 3);
        check_eq("run_locked_ok", locked_ok, 1);
        check_eq("run_pll_rst", pll_rst, 0);
        check_eq("run_loss", loss_count, exp_loss);
        check_eq("run_retry", retry_count, exp_retry);

        // One-cycle lock glitch while running counts as a loss.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check_eq("glitch_still_run", sys_reset, 0);
        tick();
        exp_loss++;
        check_eq("glitch_sys_reset", sys_reset, 1);
        check_eq("glitch_state", seq_state, 1);
        check_eq("glitch_loss", loss_count, exp_loss);
        tick();
        check_eq("glitch_restable", seq_state, 2);
        exp_q.push_back(STB);
        wait_cond(0, 100, n);
        check_eq("requalify", n, exp_q.pop_front());

        // Soft reset from RUN: full PLL reset pulse, counters kept.
        pulse_soft_rst();
        check_eq("soft_run_state", seq_state, 0);
        check_eq("soft_run_sys_rst", sys_reset, 1);
        check_eq("soft_run_tmo", timeout_err, 0);
        check_eq("soft_run_loss", loss_count, exp_loss);
        count_pll_rst(cnt);
        check_eq("pll_rst_len_soft", cnt, RST + 1);
        check_eq("soft_run_wait", seq_state, 1);

        // Lock glitch during qualification restarts the stable count.
        wait_cond(2, 50, n);
        check_eq("wait_to_stable", n, 1);
        repeat (4) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        exp_q.push_back(3 + 1 + STB - 1);
        wait_cond(0, 100, n);
        check_eq("stable_glitch_to_run", n, exp_q.pop_front());
        check_eq("stable_glitch_loss", loss_count, exp_loss);

        // Lock lost for good: repeated timeouts, one soft reset landing on a
        // timeout cycle, retry_count saturating.
        pll_locked = 1'b0;
        exp_loss++;
        exp_q.push_back(3 + TMO - 1 + 1);
        for (int i = 1; i <= 17; i++) begin
            wait_cond(1, 200, n);
            check_eq("timeout_gap", n, exp_q.pop_front());
            exp_retry = (i < SAT) ? i : SAT;
            check_eq("retry_count", retry_count, exp_retry);
            check_eq("timeout_state", seq_state, 0);
            if (i == 1) begin
                check_eq("timeout_loss", loss_count, exp_loss);
                tick();
                check_eq("timeout_width", timeout_err, 0);
                exp_q.push_back(RST + 1 + TMO - 1);
            end else if (i == 3) begin
                repeat (RST + 1 + TMO - 1) tick();
                check_eq("pre_tmo_state", seq_state, 1);
                pulse_soft_rst();
                check_eq("soft_tmo_err", timeout_err, 0);
                check_eq("soft_tmo_state", seq_state, 0);
                check_eq("soft_tmo_retry", retry_count, exp_retry);
                count_pll_rst(cnt);
                check_eq("pll_rst_len_soft_tmo", cnt, RST + 1);
                exp_q.push_back(TMO);
            end else if (i < 17) begin
                exp_q.push_back(RST + 1 + TMO);
            end
        end

        // Block reset in the middle of qualification clears everything.
        pll_locked = 1'b1;
        wait_cond(2, 100, n);
        check_eq("relock_stable", seq_state, 2);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_values("mid_rst");
        reset = 1'b0;
        exp_q.push_back(RST + 1 + 1 + STB);
        wait_cond(0, 100, n);
        check_eq("post_reset_run", n, exp_q.pop_front());
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
